// File: rtl/cpu_pkg.sv
// Shared definitions for the ALU issue controller: widths, instruction field
// positions, opcode encodings and the controller FSM state type.
package cpu_pkg;

    localparam int unsigned DW       = 24;
    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned OP_W     = 4;
    localparam int unsigned REG_AW   = 4;
    localparam int unsigned NUM_REGS = 16;

    // Instruction layout: [15:12] op, [11:8] rd, [7:4] ra, [3:0] rb
    localparam int unsigned OP_LSB = 12;
    localparam int unsigned RD_LSB = 8;
    localparam int unsigned RA_LSB = 4;
    localparam int unsigned RB_LSB = 0;

    localparam logic [OP_W-1:0] OP_ADD = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB = 4'h1;
    localparam logic [OP_W-1:0] OP_MUL = 4'h2;
    localparam logic [OP_W-1:0] OP_XOR = 4'h3;
    localparam logic [OP_W-1:0] OP_INV = 4'h4;
    localparam logic [OP_W-1:0] OP_AND = 4'h5;
    localparam logic [OP_W-1:0] OP_OR  = 4'h6;
    localparam logic [OP_W-1:0] OP_LDI = 4'h8;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    // Opcodes 0..6 are forwarded to the ALU
    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return (op <= OP_OR);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 16 x DW register file: two combinational operand read ports, one debug read
// port and one synchronous write port. r0 always reads zero and ignores writes.
// Ports: clk/rst_n; we_i/waddr_i/wdata_i write port; raddr_{a,b,dbg}_i and
// rdata_{a,b,dbg}_o read ports.
module alu_regfile #(
    parameter int unsigned DW = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we_i,
    input  logic [cpu_pkg::REG_AW-1:0] waddr_i,
    input  logic [DW-1:0]              wdata_i,
    input  logic [cpu_pkg::REG_AW-1:0] raddr_a_i,
    input  logic [cpu_pkg::REG_AW-1:0] raddr_b_i,
    input  logic [cpu_pkg::REG_AW-1:0] raddr_dbg_i,
    output logic [DW-1:0]              rdata_a_o,
    output logic [DW-1:0]              rdata_b_o,
    output logic [DW-1:0]              rdata_dbg_o
);
    import cpu_pkg::*;

    logic [DW-1:0] rf_q [NUM_REGS];

    // Storage; writes to r0 are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            rf_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o   = (raddr_a_i   == '0) ? '0 : rf_q[raddr_a_i];
    assign rdata_b_o   = (raddr_b_i   == '0) ? '0 : rf_q[raddr_b_i];
    assign rdata_dbg_o = (raddr_dbg_i == '0) ? '0 : rf_q[raddr_dbg_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for a DW-bit ALU: accepts 16-bit instructions on a
// valid/ready handshake, reads operands from the register file, drives the
// ALU, waits ALU_LAT edges, then writes alu_result back to rd.
// Ports: instr/instr_valid/instr_ready instruction handshake; alu_a/alu_b/
// alu_op/alu_result ALU interface; done/illegal_op retire pulses;
// dbg_addr/dbg_data debug read; flag_z/flag_n status flags.
// Optional feature macro: ALU_STATUS_FLAGS_EN (flags track every rf write;
// when undefined the flags are tied low).
module alu_issue_ctrl #(
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned DW      = cpu_pkg::DW
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [cpu_pkg::INSTR_W-1:0] instr,
    input  logic                        instr_valid,
    output logic                        instr_ready,
    output logic [DW-1:0]               alu_a,
    output logic [DW-1:0]               alu_b,
    output logic [cpu_pkg::OP_W-1:0]    alu_op,
    input  logic [DW-1:0]               alu_result,
    output logic                        done,
    output logic                        illegal_op,
    input  logic [cpu_pkg::REG_AW-1:0]  dbg_addr,
    output logic [DW-1:0]               dbg_data,
    output logic                        flag_z,
    output logic                        flag_n
);
    import cpu_pkg::*;

    localparam int unsigned CNT_W = 4;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [REG_AW-1:0]  rd_q, rd_d;
    logic [DW-1:0]      alu_a_q, alu_a_d;
    logic [DW-1:0]      alu_b_q, alu_b_d;
    logic [OP_W-1:0]    alu_op_q, alu_op_d;
    logic               done_q, done_d;
    logic               illegal_q, illegal_d;

    logic [OP_W-1:0]    op_f;
    logic [REG_AW-1:0]  rd_f, ra_f, rb_f;
    logic               rf_we;
    logic [REG_AW-1:0]  rf_waddr;
    logic [DW-1:0]      rf_wdata;
    logic [DW-1:0]      rf_rdata_a, rf_rdata_b;

    assign op_f = instr[OP_LSB +: OP_W];
    assign rd_f = instr[RD_LSB +: REG_AW];
    assign ra_f = instr[RA_LSB +: REG_AW];
    assign rb_f = instr[RB_LSB +: REG_AW];

    alu_regfile #(.DW(DW)) u_regfile (
        .clk         (clk),
        .rst_n       (rst_n),
        .we_i        (rf_we),
        .waddr_i     (rf_waddr),
        .wdata_i     (rf_wdata),
        .raddr_a_i   (ra_f),
        .raddr_b_i   (rb_f),
        .raddr_dbg_i (dbg_addr),
        .rdata_a_o   (rf_rdata_a),
        .rdata_b_o   (rf_rdata_b),
        .rdata_dbg_o (dbg_data)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_q      <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state, issue and writeback decisions
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = rd_f;
        rf_wdata  = '0;

        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    if (is_alu_op(op_f)) begin
                        alu_a_d  = rf_rdata_a;
                        alu_b_d  = rf_rdata_b;
                        alu_op_d = op_f;
                        rd_d     = rd_f;
                        cnt_d    = CNT_W'(ALU_LAT - 1);
                        state_d  = EXEC;
                    end else if (op_f == OP_LDI) begin
                        // Immediate write lands at the accept edge; no EXEC visit
                        rf_we    = 1'b1;
                        rf_waddr = rd_f;
                        rf_wdata = DW'({ra_f, rb_f});
                        done_d   = 1'b1;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    rf_we    = 1'b1;
                    rf_waddr = rd_q;
                    rf_wdata = alu_result;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign instr_ready = (state_q == IDLE);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign done        = done_q;
    assign illegal_op  = illegal_q;

`ifdef ALU_STATUS_FLAGS_EN
    logic flag_z_q, flag_n_q;

    // Flags follow every register write, including discarded r0 writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else if (rf_we) begin
            flag_z_q <= (rf_wdata == '0);
            flag_n_q <= rf_wdata[DW-1];
        end
    end

    assign flag_z = flag_z_q;
    assign flag_n = flag_n_q;
`else
    assign flag_z = 1'b0;
    assign flag_n = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed scoreboard bench for alu_issue_ctrl: one instance with ALU_LAT=1
// (index 0) and one with ALU_LAT=3 (index 1), each fed by a behavioral ALU.
module tb_alu_issue_ctrl;

`ifdef ALU_STATUS_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    typedef struct {
        int          s;
        bit          wr;
        bit          ill;
        logic [3:0]  rd;
        logic [23:0] val;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr       [2];
    logic        instr_valid [2];
    logic        instr_ready [2];
    logic [23:0] alu_a       [2];
    logic [23:0] alu_b       [2];
    logic [3:0]  alu_op      [2];
    logic [23:0] alu_result  [2];
    logic        done        [2];
    logic        illegal_op  [2];
    logic [3:0]  dbg_addr    [2];
    logic [23:0] dbg_data    [2];
    logic        flag_z      [2];
    logic        flag_n      [2];

    logic [23:0] exp_rf [2][16];
    logic [3:0]  exp_op [2];
    logic        ez [2];
    logic        en [2];
    exp_t        sbq [$];

    int checks;
    int failures;

    function automatic logic [23:0] alu_f(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b);
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a * b;
            4'h3:    return a ^ b;
            4'h4:    return ~a;
            4'h5:    return a & b;
            4'h6:    return a | b;
            default: return 24'h0;
        endcase
    endfunction

    assign alu_result[0] = alu_f(alu_op[0], alu_a[0], alu_b[0]);
    assign alu_result[1] = alu_f(alu_op[1], alu_a[1], alu_b[1]);

    alu_issue_ctrl #(.ALU_LAT(1), .DW(24)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .instr(instr[0]), .instr_valid(instr_valid[0]),
        .instr_ready(instr_ready[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_op(alu_op[0]),
        .alu_result(alu_result[0]), .done(done[0]), .illegal_op(illegal_op[0]),
        .dbg_addr(dbg_addr[0]), .dbg_data(dbg_data[0]), .flag_z(flag_z[0]), .flag_n(flag_n[0])
    );

    alu_issue_ctrl #(.ALU_LAT(3), .DW(24)) u_dut_l3 (
        .clk(clk), .rst_n(rst_n), .instr(instr[1]), .instr_valid(instr_valid[1]),
        .instr_ready(instr_ready[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_op(alu_op[1]),
        .alu_result(alu_result[1]), .done(done[1]), .illegal_op(illegal_op[1]),
        .dbg_addr(dbg_addr[1]), .dbg_data(dbg_data[1]), .flag_z(flag_z[1]), .flag_n(flag_n[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 2; s++) begin
            for (int r = 0; r < 16; r++) exp_rf[s][r] = 24'h0;
            exp_op[s] = 4'h0;
            ez[s] = 1'b0;
            en[s] = 1'b0;
        end
        sbq.delete();
    endtask

    // Present one instruction, wait for acceptance, push its expected outcome
    task automatic issue(input int s, input logic [3:0] op, input logic [3:0] rd,
                         input logic [3:0] ra, input logic [3:0] rb);
        exp_t e;
        int w;
        w = 0;
        @(negedge clk);
        instr[s] = {op, rd, ra, rb};
        instr_valid[s] = 1'b1;
        while (!instr_ready[s] && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", 32'(instr_ready[s]), 32'd1);
        e.s = s; e.rd = rd; e.wr = 1'b0; e.ill = 1'b0; e.val = 24'h0; e.lat = 1;
        if (op <= 4'h6) begin
            e.wr  = 1'b1;
            e.val = alu_f(op, exp_rf[s][ra], exp_rf[s][rb]);
            e.lat = (s == 0) ? 2 : 4;
            exp_op[s] = op;
        end else if (op == 4'h8) begin
            e.wr  = 1'b1;
            e.val = {16'h0, ra, rb};
        end else begin
            e.ill = 1'b1;
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
        instr_valid[s] = 1'b0;
    endtask

    // Wait for the retire pulse of the oldest issued instruction and check it
    task automatic retire(input string tag);
        exp_t e;
        int n;
        int lowr;
        n = 0;
        lowr = 0;
        if (sbq.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sbq.pop_front();
        do begin
            @(negedge clk);
            n++;
            if (!instr_ready[e.s]) lowr++;
        end while (!(done[e.s] || illegal_op[e.s]) && n < 30);
        check({tag, "_lat"}, 32'(n), 32'(e.lat));
        check({tag, "_done"}, 32'(done[e.s]), 32'(e.wr));
        check({tag, "_illegal"}, 32'(illegal_op[e.s]), 32'(e.ill));
        check({tag, "_ready_low"}, 32'(lowr), 32'(e.lat - 1));
        check({tag, "_alu_op"}, 32'(alu_op[e.s]), 32'(exp_op[e.s]));
        if (e.wr) begin
            if (e.rd != 4'h0) exp_rf[e.s][e.rd] = e.val;
            ez[e.s] = (e.val == 24'h0);
            en[e.s] = e.val[23];
        end
        dbg_addr[e.s] = e.rd;
        #1;
        check({tag, "_rd_val"}, 32'(dbg_data[e.s]), 32'(exp_rf[e.s][e.rd]));
        check({tag, "_flag_z"}, 32'(flag_z[e.s]), 32'(FLAGS_ON & ez[e.s]));
        check({tag, "_flag_n"}, 32'(flag_n[e.s]), 32'(FLAGS_ON & en[e.s]));
        if (e.ill) begin
            for (int r = 0; r < 16; r++) begin
                dbg_addr[e.s] = 4'(r);
                #1;
                check({tag, "_rf_kept"}, 32'(dbg_data[e.s]), 32'(exp_rf[e.s][r]));
            end
        end
        @(negedge clk);
        check({tag, "_pulse_end"}, 32'({done[e.s], illegal_op[e.s]}), 32'd0);
    endtask

    initial begin : main
        int acc [2];
        int na;
        int nd;

        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            instr[s] = 16'h0;
            instr_valid[s] = 1'b0;
            dbg_addr[s] = 4'h0;
        end
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state of both instances
        for (int s = 0; s < 2; s++) begin
            check("rst_ready", 32'(instr_ready[s]), 32'd1);
            check("rst_done", 32'({done[s], illegal_op[s]}), 32'd0);
            check("rst_alu_a", 32'(alu_a[s]), 32'd0);
            check("rst_alu_op", 32'(alu_op[s]), 32'd0);
            check("rst_flags", 32'({flag_z[s], flag_n[s]}), 32'd0);
        end

        // Reset during EXEC abandons the add
        issue(0, 4'h8, 4'd1, 4'h0, 4'h5);
        retire("pre_ldi_r1");
        issue(0, 4'h0, 4'd3, 4'd1, 4'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_done", 32'(done[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        check("midrst_ready", 32'(instr_ready[0]), 32'd1);
        check("midrst_done2", 32'(done[0]), 32'd0);
        check("midrst_alu_a", 32'(alu_a[0]), 32'd0);
        for (int r = 0; r < 16; r++) begin
            dbg_addr[0] = 4'(r);
            #1;
            check("midrst_rf_zero", 32'(dbg_data[0]), 32'd0);
        end

        // LDI, LDI, add
        issue(0, 4'h8, 4'd1, 4'h0, 4'h5);
        retire("ldi_r1_5");
        issue(0, 4'h8, 4'd2, 4'h0, 4'h3);
        retire("ldi_r2_3");
        issue(0, 4'h0, 4'd3, 4'd1, 4'd2);
        retire("add_r3");
        dbg_addr[0] = 4'd3;
        #1;
        check("add_r3_const", 32'(dbg_data[0]), 32'h000008);

        // Zero and negative results
        issue(0, 4'h8, 4'd1, 4'h0, 4'h0);
        retire("ldi_r1_0");
        issue(0, 4'h1, 4'd2, 4'd1, 4'd1);
        retire("sub_r2_zero");
        check("sub_zero_flag", 32'(flag_z[0]), 32'(FLAGS_ON));
        issue(0, 4'h8, 4'd5, 4'h0, 4'h1);
        retire("ldi_r5_1");
        issue(0, 4'h1, 4'd4, 4'd1, 4'd5);
        retire("sub_r4_neg");
        dbg_addr[0] = 4'd4;
        #1;
        check("sub_r4_const", 32'(dbg_data[0]), 32'hFFFFFF);
        check("sub_neg_flag", 32'({flag_z[0], flag_n[0]}), 32'({1'b0, FLAGS_ON}));

        // Illegal opcodes leave rf, flags and alu_op untouched
        issue(0, 4'h7, 4'd4, 4'd1, 4'd2);
        retire("illegal_7");
        issue(0, 4'hF, 4'd3, 4'd2, 4'd2);
        retire("illegal_f");
        check("illegal_alu_op_kept", 32'(alu_op[0]), 32'h1);

        // r0 writes are discarded but still retire
        issue(0, 4'h8, 4'd0, 4'hA, 4'hA);
        retire("ldi_r0");
        issue(0, 4'h0, 4'd1, 4'd0, 4'd0);
        retire("add_r0_r0");
        dbg_addr[0] = 4'd1;
        #1;
        check("add_r0_const", 32'(dbg_data[0]), 32'd0);

        // ALU_LAT=3: back-to-back mul with valid held high
        issue(1, 4'h8, 4'd1, 4'hF, 4'hF);
        retire("l3_ldi_r1");
        issue(1, 4'h8, 4'd2, 4'hF, 4'hF);
        retire("l3_ldi_r2");
        dbg_addr[1] = 4'd3;
        acc[0] = -1;
        acc[1] = -1;
        na = 0;
        nd = 0;
        @(negedge clk);
        instr[1] = {4'h2, 4'd3, 4'd1, 4'd2};
        instr_valid[1] = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) @(negedge clk);
            if (done[1]) begin
                nd++;
                check("mul_result", 32'(dbg_data[1]), 32'h00FE01);
            end
            if (!instr_ready[1]) begin
                check("mul_exec_a", 32'(alu_a[1]), 32'h0000FF);
                check("mul_exec_b", 32'(alu_b[1]), 32'h0000FF);
                check("mul_exec_op", 32'(alu_op[1]), 32'h2);
            end
            if (instr_valid[1] && instr_ready[1]) begin
                acc[na] = c;
                na++;
                if (na == 2) begin
                    @(posedge clk);
                    #1;
                    instr_valid[1] = 1'b0;
                end
            end
        end
        check("mul_accepts", 32'(na), 32'd2);
        check("mul_dones", 32'(nd), 32'd2);
        check("mul_spacing", 32'(acc[1] - acc[0]), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
